// File: rtl/srec_stim_loader.sv
// srec_stim_loader
//   Preload engine between the stimuli driver and the L2/TCDM data port.
//   Each accepted 64-bit entry (address, datum, byte mask) is buffered, then
//   written as up to two 32-bit words (low word first). Halves whose mask is
//   zero are skipped without bus traffic. Once the last entry is written and
//   all responses have returned, the core is released with the latched boot
//   address and fetch enable.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   stim_valid_i/stim_ready_o  entry handshake
//   stim_addr_i/data_i/be_i    entry byte address ([2:0] ignored), datum, byte mask
//   stim_last_i, entry_addr_i  final entry flag, boot address (sampled with last)
//   data_req_o .. data_err_i   PULP req/gnt/rvalid write port (we is always 1)
//   busy_o, done_o, error_o    status (error_o is sticky)
//   fetch_en_o, boot_addr_o    core release
module srec_stim_loader #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stim_valid_i,
  output logic        stim_ready_o,
  input  logic [31:0] stim_addr_i,
  input  logic [63:0] stim_data_i,
  input  logic [7:0]  stim_be_i,
  input  logic        stim_last_i,
  input  logic [31:0] entry_addr_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        fetch_en_o,
  output logic [31:0] boot_addr_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Entry buffer: storage has no reset, only the pointers do.
  logic [28:0] fifo_addr [FIFO_DEPTH];
  logic [63:0] fifo_data [FIFO_DEPTH];
  logic [7:0]  fifo_be   [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;

  logic        fifo_empty, fifo_full, push, pop;
  logic [28:0] head_addr;
  logic [63:0] head_data;
  logic [7:0]  head_be;

  logic          last_accepted_reg;
  logic [31:0]   boot_addr_reg;
  logic [CW-1:0] out_cnt_reg;
  logic          error_reg;
  logic          at_max, req_fire;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // Gating with rst_ni keeps every output low while reset is held.
  assign stim_ready_o = rst_ni & ~fifo_full & ~last_accepted_reg & (state_reg != DONE);
  assign push         = stim_valid_i & stim_ready_o;

  assign head_addr = fifo_addr[rd_ptr_reg[AW-1:0]];
  assign head_data = fifo_data[rd_ptr_reg[AW-1:0]];
  assign head_be   = fifo_be[rd_ptr_reg[AW-1:0]];

  assign at_max   = (out_cnt_reg == CW'(MAX_OUTSTANDING));
  assign req_fire = data_req_o & data_gnt_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr_reg[AW-1:0]] <= stim_addr_i[31:3];
      fifo_data[wr_ptr_reg[AW-1:0]] <= stim_data_i;
      fifo_be[wr_ptr_reg[AW-1:0]]   <= stim_be_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      last_accepted_reg <= 1'b0;
      boot_addr_reg     <= '0;
      out_cnt_reg       <= '0;
      error_reg         <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && stim_last_i) begin
        last_accepted_reg <= 1'b1;
        boot_addr_reg     <= entry_addr_i;
      end
      // A response with nothing outstanding is spurious: flag it, keep count at 0.
      if (req_fire && !(data_rvalid_i && out_cnt_reg != '0))
        out_cnt_reg <= out_cnt_reg + 1'b1;
      else if (!req_fire && data_rvalid_i && out_cnt_reg != '0)
        out_cnt_reg <= out_cnt_reg - 1'b1;
      if (data_rvalid_i && (data_err_i || out_cnt_reg == '0))
        error_reg <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic. IDLE looks at the incoming push so the first request
  // appears one cycle after the entry handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty || push)    state_next = LO;
        else if (last_accepted_reg) state_next = DRAIN;
      end
      LO: begin
        if (head_be[3:0] == 4'h0 || req_fire) state_next = HI;
      end
      HI: begin
        if (head_be[7:4] == 4'h0 || req_fire) state_next = IDLE;
      end
      DRAIN: begin
        if (out_cnt_reg == '0) state_next = DONE;
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. Address/mask/data come straight from the buffer head, which only
  // moves on pop, so they stay stable while a request waits for grant. The
  // request itself cannot drop while waiting: the outstanding count can only
  // fall until this request is granted.
  always_comb begin
    data_req_o   = 1'b0;
    data_addr_o  = '0;
    data_be_o    = '0;
    data_wdata_o = '0;
    pop          = 1'b0;
    case (state_reg)
      LO: begin
        if (head_be[3:0] != 4'h0) begin
          data_req_o   = ~at_max;
          data_addr_o  = {head_addr, 3'b000};
          data_be_o    = head_be[3:0];
          data_wdata_o = head_data[31:0];
        end
      end
      HI: begin
        if (head_be[7:4] == 4'h0) begin
          pop = 1'b1;
        end else begin
          data_req_o   = ~at_max;
          data_addr_o  = {head_addr, 3'b100};
          data_be_o    = head_be[7:4];
          data_wdata_o = head_data[63:32];
          pop          = ~at_max & data_gnt_i;
        end
      end
      default: ;
    endcase
  end

  assign data_we_o   = (state_reg == LO) || (state_reg == HI);
  assign done_o      = (state_reg == DONE);
  assign fetch_en_o  = (state_reg == DONE);
  assign boot_addr_o = (state_reg == DONE) ? boot_addr_reg : 32'h0;
  assign error_o     = error_reg;
  assign busy_o      = (state_reg != DONE) &&
                       ((state_reg != IDLE) || !fifo_empty || (out_cnt_reg != '0));

endmodule

// File: tb/tb_srec_stim_loader.sv
module tb_srec_stim_loader;

  localparam int MAXO = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stim_valid_i = 1'b0;
  logic        stim_ready_o;
  logic [31:0] stim_addr_i = '0;
  logic [63:0] stim_data_i = '0;
  logic [7:0]  stim_be_i = '0;
  logic        stim_last_i = 1'b0;
  logic [31:0] entry_addr_i = '0;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic        data_err_i = 1'b0;
  logic        busy_o, done_o, error_o, fetch_en_o;
  logic [31:0] boot_addr_o;

  srec_stim_loader #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .stim_valid_i(stim_valid_i), .stim_ready_o(stim_ready_o),
    .stim_addr_i(stim_addr_i), .stim_data_i(stim_data_i), .stim_be_i(stim_be_i),
    .stim_last_i(stim_last_i), .entry_addr_i(entry_addr_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .fetch_en_o(fetch_en_o), .boot_addr_o(boot_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;
  typedef struct { int due; bit err; } resp_t;

  wr_t   exp_q[$];
  resp_t resp_q[$];

  int cmp_cnt = 0;
  int err_cnt = 0;
  int writes_seen = 0;
  int gnt_delay = 0;
  int rv_delay = 1;
  int err_idx = -1;
  bit spurious_req = 0;

  // slave state
  int  cyc = 0;
  int  wait_cnt = 0;
  int  tb_out = 0;
  int  max_out = 0;
  int  resp_idx = 0;
  bit  gnt_fire = 0;
  bit  rv_fire = 0;
  bit  hold_pending = 0;
  wr_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave + monitor. Decisions are made on the falling edge and take
  // effect at the following rising edge.
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_err_i    = 1'b0;
      resp_q.delete();
      wait_cnt = 0; tb_out = 0; resp_idx = 0;
      gnt_fire = 0; rv_fire = 0; hold_pending = 0;
    end else begin
      if (gnt_fire) tb_out++;
      if (rv_fire && tb_out > 0) tb_out--;
      gnt_fire = 0;
      rv_fire  = 0;
      if (tb_out > max_out) max_out = tb_out;

      if (hold_pending) begin
        check("stall_req", {63'h0, data_req_o}, 64'h1);
        check("stall_addr", {32'h0, data_addr_o}, {32'h0, held.addr});
        check("stall_be", {60'h0, data_be_o}, {60'h0, held.be});
        check("stall_wdata", {32'h0, data_wdata_o}, {32'h0, held.data});
      end
      if (tb_out >= MAXO) check("req_at_max", {63'h0, data_req_o}, 64'h0);

      if (data_req_o) begin
        if (wait_cnt >= gnt_delay) begin
          wr_t e;
          data_gnt_i = 1'b1;
          wait_cnt = 0;
          gnt_fire = 1;
          hold_pending = 0;
          writes_seen++;
          $display("write addr=%h be=%h data=%h", data_addr_o, data_be_o, data_wdata_o);
          if (exp_q.size() == 0) begin
            check("unexpected_write", {32'h0, data_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", {32'h0, data_addr_o}, {32'h0, e.addr});
            check("wr_be", {60'h0, data_be_o}, {60'h0, e.be});
            check("wr_data", {32'h0, data_wdata_o}, {32'h0, e.data});
            check("wr_we", {63'h0, data_we_o}, 64'h1);
          end
          resp_q.push_back('{due: cyc + rv_delay, err: (resp_idx == err_idx)});
          resp_idx++;
        end else begin
          data_gnt_i = 1'b0;
          wait_cnt++;
          hold_pending = 1;
          held = '{addr: data_addr_o, be: data_be_o, data: data_wdata_o};
        end
      end else begin
        data_gnt_i = 1'b0;
        hold_pending = 0;
      end

      data_rvalid_i = 1'b0;
      data_err_i    = 1'b0;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        resp_t r;
        r = resp_q.pop_front();
        data_rvalid_i = 1'b1;
        data_err_i    = r.err;
        rv_fire = 1;
      end else if (spurious_req && tb_out == 0 && resp_q.size() == 0 && !gnt_fire) begin
        data_rvalid_i = 1'b1;
        spurious_req = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, {63'h0, data_req_o}, 64'h0);
    check({tag, "_ready"}, {63'h0, stim_ready_o}, 64'h0);
    check({tag, "_busy"}, {63'h0, busy_o}, 64'h0);
    check({tag, "_done"}, {63'h0, done_o}, 64'h0);
    check({tag, "_error"}, {63'h0, error_o}, 64'h0);
    check({tag, "_fetch"}, {63'h0, fetch_en_o}, 64'h0);
    check({tag, "_boot"}, {32'h0, boot_addr_o}, 64'h0);
    check({tag, "_addr"}, {32'h0, data_addr_o}, 64'h0);
  endtask

  task automatic do_reset();
    stim_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check_all_zero("reset");
    exp_q.delete();
    writes_seen = 0;
    max_out = 0;
    err_idx = -1;
    spurious_req = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic send_entry(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be,
                            input bit last, input logic [31:0] entry);
    bit ok;
    ok = 0;
    if (be[3:0] != 4'h0) exp_q.push_back('{addr: {a[31:3], 3'b000}, be: be[3:0], data: d[31:0]});
    if (be[7:4] != 4'h0) exp_q.push_back('{addr: {a[31:3], 3'b100}, be: be[7:4], data: d[63:32]});
    stim_valid_i = 1'b1;
    stim_addr_i  = a;
    stim_data_i  = d;
    stim_be_i    = be;
    stim_last_i  = last;
    entry_addr_i = entry;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (stim_ready_o) begin ok = 1; break; end
    end
    if (!ok) check("stim_accept_timeout", 64'h0, 64'h1);
    @(posedge clk_i); #1;
    stim_valid_i = 1'b0;
    stim_last_i  = 1'b0;
    $display("entry addr=%h data=%h be=%h last=%0d", a, d, be, last);
  endtask

  task automatic wait_done(input string tag, input int n_writes, input logic [31:0] boot);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      if (done_o) begin ok = 1; break; end
    end
    check({tag, "_done"}, {63'h0, done_o}, 64'h1);
    check({tag, "_fetch"}, {63'h0, fetch_en_o}, 64'h1);
    check({tag, "_boot"}, {32'h0, boot_addr_o}, {32'h0, boot});
    check({tag, "_busy"}, {63'h0, busy_o}, 64'h0);
    check({tag, "_ready"}, {63'h0, stim_ready_o}, 64'h0);
    check({tag, "_writes"}, 64'(writes_seen), 64'(n_writes));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'h0);
    if (!ok) $display("note: %s timed out waiting for done", tag);
  endtask

  initial begin
    // 1: reset state and single full entry
    do_reset();
    check("idle_ready", {63'h0, stim_ready_o}, 64'h1);
    check("idle_busy", {63'h0, busy_o}, 64'h0);
    gnt_delay = 0; rv_delay = 1;
    send_entry(32'h1C00_8004, 64'h1122_3344_5566_7788, 8'hFF, 1, 32'h1C00_8080);
    check("first_req_latency", {63'h0, data_req_o}, 64'h1);
    wait_done("single", 2, 32'h1C00_8080);
    check("single_error", {63'h0, error_o}, 64'h0);

    // 2: partial masks, including an empty mask
    do_reset();
    send_entry(32'h0000_1000, 64'hAABB_CCDD_1122_3344, 8'hF0, 0, 32'h0);
    send_entry(32'h0000_1800, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 0, 32'h0);
    send_entry(32'h0000_200B, 64'h0102_0304_9988_7766, 8'h0C, 1, 32'h0000_4000);
    wait_done("partial", 2, 32'h0000_4000);

    // 3: backpressure and full buffer
    do_reset();
    gnt_delay = 5;
    for (int i = 0; i < 6; i++) begin
      send_entry(32'h0010_0000 + 32'(i * 8), {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)},
                 8'hFF, (i == 5), 32'h0010_0100);
      if (i == 3) check("ready_low_when_full", {63'h0, stim_ready_o}, 64'h0);
    end
    wait_done("backpressure", 12, 32'h0010_0100);

    // 4: outstanding limit with late responses
    do_reset();
    gnt_delay = 0; rv_delay = 4;
    for (int i = 0; i < 3; i++)
      send_entry(32'h0020_0000 + 32'(i * 8), {32'hC000_0000 + 32'(i), 32'h3000_0000 + 32'(i)},
                 8'hFF, (i == 2), 32'h0020_0000);
    wait_done("outstanding", 6, 32'h0020_0000);
    check("max_outstanding", 64'(max_out), 64'(MAXO));

    // 5: error response on the second write, loading continues
    do_reset();
    rv_delay = 1; err_idx = 1;
    send_entry(32'h0030_0000, 64'h0000_0002_0000_0001, 8'hFF, 0, 32'h0);
    send_entry(32'h0030_0008, 64'h0000_0004_0000_0003, 8'hFF, 1, 32'h0030_0000);
    wait_done("err", 4, 32'h0030_0000);
    check("err_sticky", {63'h0, error_o}, 64'h1);

    // 6: spurious response with nothing outstanding
    do_reset();
    spurious_req = 1;
    repeat (4) @(negedge clk_i);
    check("spurious_error", {63'h0, error_o}, 64'h1);

    // 7: reset while the high half waits for grant
    do_reset();
    gnt_delay = 50;
    send_entry(32'h0040_0000, 64'h7777_7777_0000_0000, 8'hF0, 1, 32'h0040_0040);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_i);
        if (data_req_o) begin seen = 1; break; end
      end
      check("midreset_req_seen", {63'h0, seen}, 64'h1);
    end
    #3;
    gnt_delay = 0;
    do_reset();
    send_entry(32'h0050_0000, 64'h8888_8888_9999_9999, 8'hFF, 1, 32'h0050_0080);
    wait_done("after_reset", 2, 32'h0050_0080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
